// File: rtl/jellyvl_etherneco_packet_rx_buffer.sv
// -----------------------------------------------------------------------------
// jellyvl_etherneco_packet_rx_buffer
//
// Store-and-forward payload buffer behind the etherneco packet receiver.
// Payload bytes are written speculatively at wr_tmp. A packet becomes visible
// to the reader only when the receiver reports a good FCS (s_rx_end): its
// descriptor {count, type, node} is then pushed and wr_ptr catches up to
// wr_tmp. An error, RAM overflow or descriptor overflow rolls wr_tmp back to
// wr_ptr and bumps drop_count. Committed packets are replayed on a
// ready/valid byte stream with type/node/count sideband.
//
// Ports
//   reset, clk                 asynchronous active-low reset, single clock
//   s_rx_start/end/error       receiver frame pulses (open / commit / rollback)
//   s_rx_type, s_rx_node       packet header fields, latched on the first byte
//   s_first, s_last, s_data,
//   s_valid                    payload byte stream (no backpressure)
//   m_first, m_last, m_data,
//   m_valid, m_ready           replayed payload stream
//   m_type, m_node, m_count    sideband of the packet currently on m_*
//   drop_count                 saturating count of discarded packets
//   overflow                   sticky: a packet was lost for lack of space
// -----------------------------------------------------------------------------
module jellyvl_etherneco_packet_rx_buffer #(
   parameter int unsigned ADDR_WIDTH      = 10,
   parameter int unsigned META_ADDR_WIDTH = 3
) (
   input  logic        reset,
   input  logic        clk,
   input  logic        s_rx_start,
   input  logic        s_rx_end,
   input  logic        s_rx_error,
   input  logic [7:0]  s_rx_type,
   input  logic [7:0]  s_rx_node,
   input  logic        s_first,
   input  logic        s_last,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        m_first,
   output logic        m_last,
   output logic [7:0]  m_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [7:0]  m_type,
   output logic [7:0]  m_node,
   output logic [15:0] m_count,
   output logic [15:0] drop_count,
   output logic        overflow
);

   localparam int unsigned PTR_W  = ADDR_WIDTH + 1;
   localparam int unsigned MPTR_W = META_ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0]  RAM_DEPTH  = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [MPTR_W-1:0] DESC_DEPTH = {1'b1, {META_ADDR_WIDTH{1'b0}}};

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   typedef enum logic [1:0] {W_IDLE, W_RECV, W_DROP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

   logic [7:0]  ram      [2**ADDR_WIDTH];
   logic [31:0] desc_mem [2**META_ADDR_WIDTH];

   w_state_t          w_state, w_next;
   r_state_t          r_state, r_next;
   logic [PTR_W-1:0]  wr_ptr, wr_tmp, rd_ptr, used;
   logic [15:0]       wr_cnt, rem;
   logic [7:0]        wr_type, wr_node, rd_data_p1;
   logic [MPTR_W-1:0] dw_ptr, dr_ptr, df_ptr;
   logic [31:0]       desc_head;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic ram_full, desc_full, desc_empty;
   logic w_write, w_commit, w_drop, w_full_hit, w_desc_ovf, w_latch;
   logic r_pop, retire;

   // s_last is redundant: packet length comes from the byte count at commit
   logic unused_sink;
   assign unused_sink = s_last;

   assign used       = wr_tmp - rd_ptr;
   assign ram_full   = (used == RAM_DEPTH);
   // a descriptor slot is only freed once its packet has fully left m_*
   assign desc_full  = ((dw_ptr - df_ptr) == DESC_DEPTH);
   assign desc_empty = (dw_ptr == dr_ptr);
   assign desc_head  = desc_mem[dr_ptr[META_ADDR_WIDTH-1:0]];
   assign retire     = m_valid && m_ready;

   // ---------------- write FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) w_state <= W_IDLE;
      else        w_state <= w_next;
   end

   // ---------------- write FSM: next state ----------------
   always_comb begin
      w_next = w_state;
      if (w_commit || w_drop) w_next = W_IDLE;
      else if (w_full_hit)    w_next = W_DROP;
      // a start in the same clk as end/error opens the new packet after the close
      if (s_rx_start)         w_next = W_RECV;
   end

   // ---------------- write FSM: actions ----------------
   always_comb begin
      w_write    = 1'b0;
      w_commit   = 1'b0;
      w_drop     = 1'b0;
      w_full_hit = 1'b0;
      w_desc_ovf = 1'b0;
      w_latch    = 1'b0;
      case (w_state)
         W_RECV: begin
            if (s_rx_error) begin
               w_drop = 1'b1;
            end else if (s_rx_end) begin
               if (wr_cnt == 16'd0) begin
                  w_drop = 1'b1;
               end else if (desc_full) begin
                  w_drop     = 1'b1;
                  w_desc_ovf = 1'b1;
               end else begin
                  w_commit = 1'b1;
               end
            end else if (s_valid && !s_rx_start) begin
               w_latch = s_first;
               if (ram_full) w_full_hit = 1'b1;
               else          w_write    = 1'b1;
            end
         end
         W_DROP: begin
            if (s_rx_error || s_rx_end) w_drop = 1'b1;
         end
         default: ;
      endcase
   end

   // ---------------- write-side state ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         wr_tmp     <= '0;
         wr_cnt     <= '0;
         wr_type    <= '0;
         wr_node    <= '0;
         dw_ptr     <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (w_full_hit || w_desc_ovf) overflow <= 1'b1;
         if (w_drop) begin
            wr_tmp     <= wr_ptr;
            drop_count <= sat_inc16(drop_count);
         end
         if (w_commit) begin
            wr_ptr <= wr_tmp;
            dw_ptr <= dw_ptr + 1'b1;
         end
         if (s_rx_start) begin
            // after a same-clk commit wr_tmp already equals the new wr_ptr
            wr_tmp <= w_commit ? wr_tmp : wr_ptr;
            wr_cnt <= '0;
         end else if (w_write) begin
            wr_tmp <= wr_tmp + 1'b1;
            wr_cnt <= wr_cnt + 16'd1;
         end
         if (w_latch) begin
            wr_type <= s_rx_type;
            wr_node <= s_rx_node;
         end
      end
   end

   // ---------------- payload RAM and descriptor store (no reset) ----------------
   always_ff @(posedge clk) begin
      if (w_write)  ram[wr_tmp[ADDR_WIDTH-1:0]] <= s_data;
      if (w_commit) desc_mem[dw_ptr[META_ADDR_WIDTH-1:0]] <= {wr_cnt, wr_type, wr_node};
      rd_data_p1 <= ram[rd_addr];
   end

   // ---------------- read FSM: state register ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= R_IDLE;
      else        r_state <= r_next;
   end

   // ---------------- read FSM: next state ----------------
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (!desc_empty) r_next = R_FETCH;
         R_FETCH: r_next = R_DATA;
         R_DATA:  if (retire && m_last) r_next = desc_empty ? R_IDLE : R_FETCH;
         default: r_next = R_IDLE;
      endcase
   end

   // ---------------- read FSM: actions ----------------
   // rd_data_p1 always holds the byte after the one on m_data while in R_DATA,
   // so a retire can reload m_data in the same clk without a bubble.
   always_comb begin
      r_pop   = 1'b0;
      rd_addr = rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
      case (r_state)
         R_IDLE: begin
            r_pop   = !desc_empty;
            rd_addr = rd_ptr[ADDR_WIDTH-1:0];
         end
         R_DATA: begin
            if (retire && m_last) r_pop = !desc_empty;
            if (retire && !m_last) rd_addr = rd_ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(2);
         end
         default: ;
      endcase
   end

   // ---------------- output stage ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr  <= '0;
         dr_ptr  <= '0;
         df_ptr  <= '0;
         rem     <= '0;
         m_valid <= 1'b0;
         m_first <= 1'b0;
         m_last  <= 1'b0;
         m_data  <= '0;
         m_type  <= '0;
         m_node  <= '0;
         m_count <= '0;
      end else begin
         if (r_pop) begin
            dr_ptr  <= dr_ptr + 1'b1;
            m_count <= desc_head[31:16];
            m_type  <= desc_head[15:8];
            m_node  <= desc_head[7:0];
            rem     <= desc_head[31:16];
         end
         case (r_state)
            R_FETCH: begin
               m_valid <= 1'b1;
               m_first <= 1'b1;
               m_last  <= (rem == 16'd1);
               m_data  <= rd_data_p1;
            end
            R_DATA: begin
               if (retire) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  if (m_last) begin
                     m_valid <= 1'b0;
                     m_first <= 1'b0;
                     m_last  <= 1'b0;
                     df_ptr  <= df_ptr + 1'b1;
                  end else begin
                     m_data  <= rd_data_p1;
                     m_first <= 1'b0;
                     m_last  <= (rem == 16'd2);
                     rem     <= rem - 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jellyvl_etherneco_packet_rx_buffer.sv
// Testbench for jellyvl_etherneco_packet_rx_buffer: directed packets, expected
// output bytes queued at stimulus time, a monitor popping on every retire and
// checking the hold rule while stalled.
module tb_jellyvl_etherneco_packet_rx_buffer;

   localparam int AW    = 9;
   localparam int MAW   = 3;
   localparam int DEPTH = 1 << AW;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_rx_start = 1'b0, s_rx_end = 1'b0, s_rx_error = 1'b0;
   logic [7:0]  s_rx_type = '0, s_rx_node = '0, s_data = '0;
   logic        s_first = 1'b0, s_last = 1'b0, s_valid = 1'b0;
   logic        m_first, m_last, m_valid;
   logic        m_ready = 1'b1;
   logic [7:0]  m_data, m_type, m_node;
   logic [15:0] m_count, drop_count;
   logic        overflow;

   always #5 clk = ~clk;

   jellyvl_etherneco_packet_rx_buffer #(
      .ADDR_WIDTH      (AW),
      .META_ADDR_WIDTH (MAW)
   ) dut (
      .reset      (rst_n),
      .clk        (clk),
      .s_rx_start (s_rx_start),
      .s_rx_end   (s_rx_end),
      .s_rx_error (s_rx_error),
      .s_rx_type  (s_rx_type),
      .s_rx_node  (s_rx_node),
      .s_first    (s_first),
      .s_last     (s_last),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .m_first    (m_first),
      .m_last     (m_last),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_type     (m_type),
      .m_node     (m_node),
      .m_count    (m_count),
      .drop_count (drop_count),
      .overflow   (overflow)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [41:0] sb[$];
   int ready_mode = 1;   // 0: low, 1: high, 2: toggle every clk

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [41:0] pack(input logic f, input logic l, input logic [7:0] d,
                                        input logic [7:0] t, input logic [7:0] n,
                                        input logic [15:0] c);
      return {f, l, d, t, n, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one packet: start, len bytes, gap idle clks, then end (or error)
   task automatic send_pkt(input logic [7:0] typ, input logic [7:0] node, input int len,
                           input logic [7:0] base, input int gap,
                           input bit use_error, input bit expect_ok);
      s_rx_type  = typ;
      s_rx_node  = node;
      s_rx_start = 1'b1;
      tick();
      s_rx_start = 1'b0;
      for (int i = 0; i < len; i++) begin
         s_valid = 1'b1;
         s_data  = base + 8'(i);
         s_first = (i == 0);
         s_last  = (i == len - 1);
         tick();
      end
      s_valid = 1'b0;
      s_first = 1'b0;
      s_last  = 1'b0;
      repeat (gap) tick();
      if (expect_ok)
         for (int i = 0; i < len; i++)
            sb.push_back(pack(i == 0, i == len - 1, base + 8'(i), typ, node, 16'(len)));
      if (use_error) s_rx_error = 1'b1;
      else           s_rx_end   = 1'b1;
      tick();
      s_rx_end   = 1'b0;
      s_rx_error = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int k = 0;
      while ((sb.size() != 0 || m_valid) && k < budget) begin
         tick();
         k++;
      end
      check("drain_queue_empty", 64'(sb.size()), 64'd0);
   endtask

   task automatic check_zero_outputs(input string name);
      check(name, {m_valid, m_first, m_last, m_data, m_type, m_node, m_count, drop_count, overflow}, 64'd0);
   endtask

   task automatic do_reset(input string name);
      rst_n      = 1'b0;
      s_rx_start = 1'b0;
      s_rx_end   = 1'b0;
      s_rx_error = 1'b0;
      s_valid    = 1'b0;
      s_first    = 1'b0;
      s_last     = 1'b0;
      sb.delete();
      #1;
      check_zero_outputs(name);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
   endtask

   // m_ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = ~m_ready;
         endcase
      end
   end

   // monitor: compare every retired byte, and check the hold rule while stalled
   logic        stall_prev = 1'b0;
   logic [41:0] snap_prev  = '0;
   always @(negedge clk) begin
      logic [41:0] snap_now;
      logic [41:0] exp_item;
      snap_now = pack(m_first, m_last, m_data, m_type, m_node, m_count);
      if (!rst_n) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", 64'(m_valid), 64'd1);
            if (m_valid) check("hold_outputs", 64'(snap_now), 64'(snap_prev));
         end
         if (m_valid && m_ready) begin
            check("output_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               exp_item = sb.pop_front();
               check("out_byte", 64'(snap_now), 64'(exp_item));
            end
         end
         stall_prev = m_valid && !m_ready;
         snap_prev  = snap_now;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, %0d bytes still expected", sb.size());
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check_zero_outputs("reset_outputs");
      rst_n = 1'b1;
      tick();

      // 1: good 8-byte packet, end 5 clk after last byte, first byte 3 clk after end
      send_pkt(8'h12, 8'h03, 8, 8'h00, 5, 1'b0, 1'b1);
      tick();
      check("t1_latency_early", 64'(m_valid), 64'd0);
      tick();
      check("t1_latency_valid", 64'(m_valid), 64'd1);
      wait_drain(100);
      check("t1_drop_count", 64'(drop_count), 64'd0);

      // 2: error-terminated packet disappears, next good one passes intact
      send_pkt(8'h12, 8'h03, 8, 8'h00, 5, 1'b1, 1'b0);
      repeat (8) tick();
      check("t2_drop_count", 64'(drop_count), 64'd1);
      check("t2_no_output", 64'(m_valid), 64'd0);
      send_pkt(8'h22, 8'h05, 8, 8'h50, 1, 1'b0, 1'b1);
      wait_drain(100);
      check("t2_drop_after", 64'(drop_count), 64'd1);

      // 3: packet larger than the RAM is dropped; an exactly-full one is kept
      send_pkt(8'h33, 8'h01, DEPTH + 4, 8'h10, 2, 1'b0, 1'b0);
      check("t3_overflow", 64'(overflow), 64'd1);
      check("t3_drop_count", 64'(drop_count), 64'd2);
      send_pkt(8'h34, 8'h02, DEPTH, 8'h80, 2, 1'b0, 1'b1);
      wait_drain(DEPTH + 50);
      check("t3_overflow_sticky", 64'(overflow), 64'd1);
      check("t3_drop_after", 64'(drop_count), 64'd2);

      // clear sticky status before the descriptor test
      do_reset("reset_between_outputs");

      // 4: nine 1-byte packets with m_ready low, ninth finds no descriptor slot
      ready_mode = 0;
      tick();
      tick();
      for (int k = 0; k < 9; k++)
         send_pkt(8'(k), 8'h40 + 8'(k), 1, 8'hA0 + 8'(k), 0, 1'b0, k < 8);
      check("t4_overflow", 64'(overflow), 64'd1);
      check("t4_drop_count", 64'(drop_count), 64'd1);
      check("t4_held_first", 64'({m_valid, m_first, m_last, m_data}), 64'({1'b1, 1'b1, 1'b1, 8'hA0}));
      ready_mode = 1;
      wait_drain(200);

      // 5: 300-byte packets under 1010 m_ready, second one crosses the RAM wrap
      ready_mode = 2;
      send_pkt(8'h55, 8'h09, 300, 8'h00, 1, 1'b0, 1'b1);
      wait_drain(1000);
      send_pkt(8'h56, 8'h0A, 300, 8'h37, 1, 1'b0, 1'b1);
      wait_drain(1000);
      ready_mode = 1;
      check("t5_drop_count", 64'(drop_count), 64'd1);

      // 6: reset while one packet streams out and another is being received
      send_pkt(8'h66, 8'h07, 40, 8'h30, 0, 1'b0, 1'b1);
      s_rx_type  = 8'h77;
      s_rx_node  = 8'h08;
      s_rx_start = 1'b1;
      tick();
      s_rx_start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         s_valid = 1'b1;
         s_data  = 8'hE0 + 8'(i);
         s_first = (i == 0);
         tick();
      end
      check("t6_mid_output", 64'(m_valid), 64'd1);
      do_reset("t6_reset_outputs");
      send_pkt(8'h88, 8'h0B, 5, 8'hC0, 0, 1'b0, 1'b1);
      wait_drain(100);
      check("t6_status_after", 64'({drop_count, overflow}), 64'd0);

      repeat (5) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
